pkt_size_meter: RTL and testbench

//  Passive tap on a packet stream (valid/ready, sop/eop, empty). Measures each packet's byte

---
 rtl/pkt_size_meter.sv | 104 ++++++++++
 tb/tb_pkt_size_meter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_size_meter.sv
// Passive packet-stream tap: measures each packet's byte length and tags it with
// the flow sampled at SOP, and flags framing errors and oversize packets.
module pkt_size_meter #(
    parameter int DATA_BYTES = 8,
    parameter int EMPTY_W    = $clog2(DATA_BYTES),
    parameter int A_WIDTH    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_valid_i,
    input  logic               st_ready_i,
    input  logic               st_sop_i,
    input  logic               st_eop_i,
    input  logic [EMPTY_W-1:0] st_empty_i,
    input  logic [A_WIDTH-1:0] st_flow_num_i,
    output logic [A_WIDTH-1:0] rx_flow_num_o,
    output logic [15:0]        pkt_size_o,
    output logic               pkt_size_ena_o,
    output logic               pkt_oversize_o,
    output logic               err_no_sop_o,
    output logic               err_sop_in_pkt_o,
    output logic [15:0]        drop_cnt_o
);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t             state;
    logic [16:0]        acc;
    logic               sat;
    logic [A_WIDTH-1:0] cur_flow;

    logic        beat;
    logic [16:0] beat_bytes;
    logic [16:0] sum;
    logic        ovf;
    logic [15:0] drop_next;

    assign beat = st_valid_i & st_ready_i;

    // empty only shortens the final beat of a packet
    assign beat_bytes = st_eop_i ? 17'(DATA_BYTES) - 17'(st_empty_i)
                                 : 17'(DATA_BYTES);

    assign sum       = acc + beat_bytes;
    assign ovf       = sum > 17'h0FFFF;
    assign drop_next = (drop_cnt_o == 16'hFFFF) ? drop_cnt_o : drop_cnt_o + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            acc              <= '0;
            sat              <= 1'b0;
            cur_flow         <= '0;
            rx_flow_num_o    <= '0;
            pkt_size_o       <= '0;
            pkt_size_ena_o   <= 1'b0;
            pkt_oversize_o   <= 1'b0;
            err_no_sop_o     <= 1'b0;
            err_sop_in_pkt_o <= 1'b0;
            drop_cnt_o       <= '0;
        end else begin
            pkt_size_ena_o   <= 1'b0;
            pkt_oversize_o   <= 1'b0;
            err_no_sop_o     <= 1'b0;
            err_sop_in_pkt_o <= 1'b0;
            if (beat) begin
                if (st_sop_i) begin
                    // an SOP inside a packet abandons the open one unreported
                    if (state == IN_PKT) begin
                        err_sop_in_pkt_o <= 1'b1;
                        drop_cnt_o       <= drop_next;
                    end
                    cur_flow <= st_flow_num_i;
                    if (st_eop_i) begin
                        rx_flow_num_o  <= st_flow_num_i;
                        pkt_size_o     <= beat_bytes[15:0];
                        pkt_size_ena_o <= 1'b1;
                        acc            <= '0;
                        sat            <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        acc   <= beat_bytes;
                        sat   <= 1'b0;
                        state <= IN_PKT;
                    end
                end else if (state == IDLE) begin
                    err_no_sop_o <= 1'b1;
                    drop_cnt_o   <= drop_next;
                end else begin
                    acc <= ovf ? 17'h0FFFF : sum;
                    sat <= sat | ovf;
                    if (st_eop_i) begin
                        rx_flow_num_o  <= cur_flow;
                        pkt_size_o     <= (sat | ovf) ? 16'hFFFF : sum[15:0];
                        pkt_oversize_o <= sat | ovf;
                        pkt_size_ena_o <= 1'b1;
                        state          <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_size_meter.sv
// Directed bench for pkt_size_meter: each task drives one scenario and checks
// the registered outputs one cycle after the relevant beat.
module tb_pkt_size_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid_i, st_ready_i, st_sop_i, st_eop_i;
    logic [2:0]  st_empty_i;
    logic [2:0]  st_flow_num_i;
    logic [2:0]  rx_flow_num_o;
    logic [15:0] pkt_size_o;
    logic        pkt_size_ena_o, pkt_oversize_o;
    logic        err_no_sop_o, err_sop_in_pkt_o;
    logic [15:0] drop_cnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pkt_size_meter #(.DATA_BYTES(8), .A_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .st_valid_i(st_valid_i), .st_ready_i(st_ready_i),
        .st_sop_i(st_sop_i), .st_eop_i(st_eop_i),
        .st_empty_i(st_empty_i), .st_flow_num_i(st_flow_num_i),
        .rx_flow_num_o(rx_flow_num_o), .pkt_size_o(pkt_size_o),
        .pkt_size_ena_o(pkt_size_ena_o), .pkt_oversize_o(pkt_oversize_o),
        .err_no_sop_o(err_no_sop_o), .err_sop_in_pkt_o(err_sop_in_pkt_o),
        .drop_cnt_o(drop_cnt_o)
    );

    // drive one cycle of inputs, then land 1 time unit after the edge
    task automatic cyc(input logic v, input logic r, input logic s, input logic e,
                       input logic [2:0] emp, input logic [2:0] fl);
        st_valid_i = v; st_ready_i = r; st_sop_i = s; st_eop_i = e;
        st_empty_i = emp; st_flow_num_i = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        tests++;
        if ({rx_flow_num_o, pkt_size_o, pkt_size_ena_o, pkt_oversize_o,
             err_no_sop_o, err_sop_in_pkt_o, drop_cnt_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: size=%0h ena=%0b drop=%0h want all 0",
                     pkt_size_o, pkt_size_ena_o, drop_cnt_o);
        end
        #2 rst = 1'b0;
        idle();
    endtask

    task automatic test_single_beat();
        cyc(1, 1, 1, 1, 3, 2);
        tests++;
        if (pkt_size_ena_o !== 1'b1 || rx_flow_num_o !== 3'd2 || pkt_size_o !== 16'd5) begin
            fails++;
            $display("FAIL single_beat: ena=%0b flow=%0d size=%0d want 1/2/5",
                     pkt_size_ena_o, rx_flow_num_o, pkt_size_o);
        end
        idle();
        tests++;
        if (pkt_size_ena_o !== 1'b0 || pkt_size_o !== 16'd5 || rx_flow_num_o !== 3'd2) begin
            fails++;
            $display("FAIL single_beat_hold: ena=%0b flow=%0d size=%0d want 0/2/5",
                     pkt_size_ena_o, rx_flow_num_o, pkt_size_o);
        end
    endtask

    task automatic test_multi_pkt();
        int strobes = 0;
        int total = 0;
        int bad = 0;
        for (int p = 0; p < 7; p++) begin
            for (int b = 0; b < 13; b++) begin
                cyc(1, 1, b == 0, b == 12, (b == 12) ? 3'd4 : 3'd0, 0);
                if (pkt_size_ena_o) begin
                    strobes++;
                    total += pkt_size_o;
                    if (pkt_size_o !== 16'd100 || rx_flow_num_o !== 3'd0) bad++;
                end
            end
        end
        idle();
        if (pkt_size_ena_o) begin
            strobes++;
            total += pkt_size_o;
        end
        tests++;
        if (strobes != 7) begin
            fails++;
            $display("FAIL multi_strobes: got %0d want 7", strobes);
        end
        tests++;
        if (total != 700 || bad != 0) begin
            fails++;
            $display("FAIL multi_total: got %0d (bad records %0d) want 700", total, bad);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 5, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 2, 0);
        tests++;
        if (pkt_size_ena_o !== 1'b1 || rx_flow_num_o !== 3'd1 || pkt_size_o !== 16'd22) begin
            fails++;
            $display("FAIL gaps_pkt: ena=%0b flow=%0d size=%0d want 1/1/22",
                     pkt_size_ena_o, rx_flow_num_o, pkt_size_o);
        end
        cyc(1, 1, 1, 1, 0, 0);
        tests++;
        if (pkt_size_ena_o !== 1'b1 || rx_flow_num_o !== 3'd0 || pkt_size_o !== 16'd8) begin
            fails++;
            $display("FAIL b2b_pkt: ena=%0b flow=%0d size=%0d want 1/0/8",
                     pkt_size_ena_o, rx_flow_num_o, pkt_size_o);
        end
        idle();
        tests++;
        if (drop_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL b2b_no_errors: drop=%0d want 0", drop_cnt_o);
        end
    endtask

    task automatic test_sop_in_pkt();
        cyc(1, 1, 1, 0, 0, 3);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 5);
        tests++;
        if (err_sop_in_pkt_o !== 1'b1 || pkt_size_ena_o !== 1'b0 || drop_cnt_o !== 16'd1) begin
            fails++;
            $display("FAIL sop_in_pkt_err: err=%0b ena=%0b drop=%0d want 1/0/1",
                     err_sop_in_pkt_o, pkt_size_ena_o, drop_cnt_o);
        end
        cyc(1, 1, 0, 1, 0, 0);
        tests++;
        if (pkt_size_ena_o !== 1'b1 || rx_flow_num_o !== 3'd5 || pkt_size_o !== 16'd16
            || err_sop_in_pkt_o !== 1'b0) begin
            fails++;
            $display("FAIL sop_in_pkt_rec: ena=%0b flow=%0d size=%0d want 1/5/16",
                     pkt_size_ena_o, rx_flow_num_o, pkt_size_o);
        end
        idle();
        cyc(1, 1, 0, 0, 0, 6);
        tests++;
        if (err_no_sop_o !== 1'b1 || drop_cnt_o !== 16'd2 || pkt_size_ena_o !== 1'b0) begin
            fails++;
            $display("FAIL no_sop: err=%0b drop=%0d ena=%0b want 1/2/0",
                     err_no_sop_o, drop_cnt_o, pkt_size_ena_o);
        end
        idle();
        tests++;
        if (err_no_sop_o !== 1'b0) begin
            fails++;
            $display("FAIL no_sop_pulse: err=%0b want 0", err_no_sop_o);
        end
    endtask

    // nfull full beats then an eop beat with the given empty
    task automatic send_long(input int nfull, input logic [2:0] emp);
        cyc(1, 1, 1, 0, 0, 7);
        for (int i = 1; i < nfull; i++) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, emp, 0);
    endtask

    task automatic test_oversize();
        send_long(8191, 3'd1);
        tests++;
        if (pkt_size_ena_o !== 1'b1 || pkt_size_o !== 16'hFFFF || pkt_oversize_o !== 1'b0) begin
            fails++;
            $display("FAIL exact_65535: ena=%0b size=%0h ovs=%0b want 1/ffff/0",
                     pkt_size_ena_o, pkt_size_o, pkt_oversize_o);
        end
        idle();
        send_long(8200, 3'd0);
        tests++;
        if (pkt_size_ena_o !== 1'b1 || pkt_size_o !== 16'hFFFF || pkt_oversize_o !== 1'b1
            || rx_flow_num_o !== 3'd7) begin
            fails++;
            $display("FAIL oversize: ena=%0b size=%0h ovs=%0b flow=%0d want 1/ffff/1/7",
                     pkt_size_ena_o, pkt_size_o, pkt_oversize_o, rx_flow_num_o);
        end
        idle();
        tests++;
        if (pkt_oversize_o !== 1'b0 || pkt_size_ena_o !== 1'b0) begin
            fails++;
            $display("FAIL oversize_pulse: ovs=%0b ena=%0b want 0/0",
                     pkt_oversize_o, pkt_size_ena_o);
        end
    endtask

    task automatic test_reset_mid_pkt();
        int strobes = 0;
        cyc(1, 1, 1, 0, 0, 4);
        cyc(1, 1, 0, 0, 0, 0);
        st_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({rx_flow_num_o, pkt_size_o, pkt_size_ena_o, drop_cnt_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid: flow=%0d size=%0d drop=%0d want 0/0/0",
                     rx_flow_num_o, pkt_size_o, drop_cnt_o);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int b = 0; b < 5; b++) begin
            cyc(1, 1, b == 0, b == 4, 0, 6);
            if (pkt_size_ena_o) strobes++;
        end
        tests++;
        if (strobes != 1 || pkt_size_o !== 16'd40 || rx_flow_num_o !== 3'd6
            || drop_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL after_reset: strobes=%0d size=%0d flow=%0d drop=%0d want 1/40/6/0",
                     strobes, pkt_size_o, rx_flow_num_o, drop_cnt_o);
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        st_valid_i = 0; st_ready_i = 1; st_sop_i = 0; st_eop_i = 0;
        st_empty_i = 0; st_flow_num_i = 0;
        test_reset();
        test_single_beat();
        test_multi_pkt();
        test_back_to_back();
        test_sop_in_pkt();
        test_oversize();
        test_reset_mid_pkt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
